// File: rtl/scan_drv_pkg.sv
// rtl/scan_drv_pkg.sv - shared types and constants for the scan chain driver
package scan_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    CMP
  } scan_state_t;

  localparam logic FILL_BIT_DEFAULT = 1'b0;

  // Wide enough to hold a count of 0..chain_len inclusive.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_resp_cmp.sv
// rtl/scan_resp_cmp.sv - response vs expected compare and popcount
// Optional SCAN_DRV_XMASK_EN excludes masked bits from the count.
module scan_resp_cmp
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic [CHAIN_LEN-1:0] resp,
  input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_DRV_XMASK_EN
  input  logic [CHAIN_LEN-1:0] mask,
`endif
  output logic [CNT_W-1:0]     fail_count
);

  logic [CHAIN_LEN-1:0] diff;

  always_comb begin
`ifdef SCAN_DRV_XMASK_EN
    diff = (resp ^ expected) & ~mask;
`else
    diff = resp ^ expected;
`endif
    fail_count = '0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      fail_count = fail_count + CNT_W'(diff[i]);
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// rtl/scan_chain_driver.sv - load/capture/unload master for one negedge scan chain
// Optional SCAN_DRV_XMASK_EN adds a per-bit compare mask port.
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int   CHAIN_LEN = 16,
  parameter logic FILL_BIT  = FILL_BIT_DEFAULT,
  parameter int   CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_DRV_XMASK_EN
  input  logic [CHAIN_LEN-1:0] mask,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CHAIN_LEN-1:0] resp,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pattern_q;
  logic [CHAIN_LEN-1:0] expected_q;
  logic [CNT_W-1:0]     cmp_count;
`ifdef SCAN_DRV_XMASK_EN
  logic [CHAIN_LEN-1:0] mask_q;
`endif

  scan_resp_cmp #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_cmp (
    .resp       (resp),
    .expected   (expected_q),
`ifdef SCAN_DRV_XMASK_EN
    .mask       (mask_q),
`endif
    .fail_count (cmp_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      pattern_q  <= '0;
      expected_q <= '0;
`ifdef SCAN_DRV_XMASK_EN
      mask_q     <= '0;
`endif
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      resp       <= '0;
      SE         <= 1'b0;
      SI         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          SE <= 1'b0;
          if (start) begin
            pattern_q  <= pattern;
            expected_q <= expected;
`ifdef SCAN_DRV_XMASK_EN
            mask_q     <= mask;
`endif
            cnt        <= '0;
            busy       <= 1'b1;
            SE         <= 1'b1;
            SI         <= pattern[CHAIN_LEN-1];
            state      <= LOAD;
          end
        end
        // Rotating the latched pattern keeps the next MSB-first bit at a fixed index.
        LOAD: begin
          if (cnt == LAST) begin
            SE    <= 1'b0;
            SI    <= FILL_BIT;
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            pattern_q <= {pattern_q[CHAIN_LEN-2:0], pattern_q[CHAIN_LEN-1]};
            SI        <= pattern_q[CHAIN_LEN-2];
            cnt       <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          resp  <= {resp[CHAIN_LEN-2:0], SO};
          SE    <= 1'b1;
          SI    <= FILL_BIT;
          cnt   <= '0;
          state <= UNLOAD;
        end
        // First sample already taken leaving CAPTURE; the last UNLOAD edge takes none.
        UNLOAD: begin
          if (cnt != LAST) begin
            resp <= {resp[CHAIN_LEN-2:0], SO};
          end
          if (cnt == LAST) begin
            SE    <= 1'b0;
            cnt   <= '0;
            state <= CMP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMP: begin
          fail_count <= cmp_count;
          pass       <= (cmp_count == '0);
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          SE    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// tb/tb_scan_chain_driver.sv - scoreboard bench with a behavioural 4-flop negedge scan chain
module tb_scan_chain_driver;

  localparam int   N    = 4;
  localparam int   CW   = $clog2(N + 1);
  localparam logic FILL = 1'b0;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  pattern = '0;
  logic [N-1:0]  expected = '0;
  logic [N-1:0]  mask = '0;
  logic          busy, done, pass, SE, SI, SO;
  logic [CW-1:0] fail_count;
  logic [N-1:0]  resp;

  logic [N-1:0]  d_in = '0;
  logic [N-1:0]  chain = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0]  resp;
    logic          pass;
    logic [CW-1:0] fc;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) chain <= SE ? {chain[N-2:0], SI} : d_in;
  assign SO = chain[N-1];

  scan_chain_driver #(.CHAIN_LEN(N), .FILL_BIT(FILL)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .pattern    (pattern),
    .expected   (expected),
`ifdef SCAN_DRV_XMASK_EN
    .mask       (mask),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .resp       (resp),
    .SE         (SE),
    .SI         (SI),
    .SO         (SO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp", 32'(resp), 32'(e.resp));
        check("pass", 32'(pass), 32'(e.pass));
        check("fail_count", 32'(fail_count), 32'(e.fc));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_SE"}, 32'(SE), 32'd0);
    check({tag, "_SI"}, 32'(SI), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    check({tag, "_resp"}, 32'(resp), 32'd0);
  endtask

  // One full operation; optionally a spurious start in LOAD or a reset at cycle reset_at.
  task automatic run_op(input logic [N-1:0] pat, input logic [N-1:0] dval,
                        input logic [N-1:0] exv, input logic [N-1:0] msk,
                        input bit busy_start, input int reset_at);
    exp_t          e;
    logic [N-1:0]  eff_mask;
    logic [2*N+1:0] se_tr, se_exp;
    logic [2*N:0]   si_tr, si_exp;
    int            start_edge;
`ifdef SCAN_DRV_XMASK_EN
    eff_mask = msk;
`else
    eff_mask = '0;
`endif
    pattern  = pat;
    expected = exv;
    mask     = msk;
    d_in     = dval;
    start    = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    start_edge = cyc;
    check("busy_after_start", 32'(busy), 32'd1);
    e.resp = dval;
    e.fc   = CW'($countones((dval ^ exv) & ~eff_mask));
    e.pass = (e.fc == '0);
    e.cyc  = start_edge + 2 * N + 2;
    exp_q.push_back(e);
    for (int c = 0; c < 2 * N + 2; c++) begin
      se_tr[c]  = SE;
      se_exp[c] = (c < N) || (c > N && c <= 2 * N);
      if (c <= 2 * N) begin
        si_tr[c]  = SI;
        si_exp[c] = (c < N) ? pat[N-1-c] : FILL;
      end
      if (c == reset_at) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        check_reset_outputs("mid_reset");
        return;
      end
      if (busy_start && c == 2) begin
        start    = 1'b1;
        pattern  = '0;
        expected = '0;
      end
      @(posedge CLK); #1;
      start = 1'b0;
    end
    check("se_profile", 32'(se_tr), 32'(se_exp));
    check("si_sequence", 32'(si_tr), 32'(si_exp));
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge CLK); #1;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rp, rd, re;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");

    start = 1'b1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    start = 1'b0;
    check("start_with_rst_busy", 32'(busy), 32'd0);

    run_op(4'b1011, 4'b0110, 4'b0110, 4'b0000, 1'b0, -1);
    run_op(4'b1011, 4'b0111, 4'b0110, 4'b0000, 1'b0, -1);
    run_op(4'b1101, 4'b0101, 4'b0101, 4'b0000, 1'b1, -1);
    run_op(4'b1011, 4'b0110, 4'b0110, 4'b0000, 1'b0, 2 * N - 1);
    run_op(4'b0011, 4'b1001, 4'b1000, 4'b0000, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      rp = N'($urandom);
      rd = N'($urandom);
      re = ($urandom_range(0, 2) == 0) ? rd : N'($urandom);
      run_op(rp, rd, re, 4'b0000, 1'b0, -1);
    end

`ifdef SCAN_DRV_XMASK_EN
    run_op(4'b1010, 4'b1111, 4'b0000, 4'b1100, 1'b0, -1);
    run_op(4'b0101, 4'b1001, 4'b0001, 4'b1000, 1'b0, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
